// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Brief  : Shared types and constants for the restoring divider sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, hence the +1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_if.sv
// ============================================================================
// Module : div_if
// Brief  : Request/result bundle between a divider client and the sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, abort, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, abort, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring shift-subtract iteration.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH:0]   rem,
    input  wire logic [WIDTH-1:0] quo,
    input  wire logic [WIDTH-1:0] divisor,
    output logic      [WIDTH:0]   rem_next,
    output logic      [WIDTH-1:0] quo_next
);
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_trial;

    // Two guard bits: one for the shifted-in MSB, one as the trial sign.
    assign w_shifted = {rem, quo[WIDTH-1]};
    assign w_trial   = w_shifted - {2'b00, divisor};

    always_comb begin
        rem_next = w_shifted[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH+1]) begin
            rem_next = w_trial[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module : div_sequencer
// Brief  : Restoring divider controller, one quotient bit per clock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_accept;
    logic             w_zero;
    logic             w_last;

    assign w_accept = (r_state == IDLE) && bus.start && !bus.abort;
    assign w_zero   = (bus.divisor == '0);
    assign w_last   = (r_cnt == CW'(1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_div),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_zero ? DONE : CALC;
            CALC: begin
                if (bus.abort)   w_state_next = IDLE;
                else if (w_last) w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_zero) begin
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_div <= bus.divisor;
                r_quo <= bus.dividend;
                r_rem <= '0;
                r_cnt <= CW'(WIDTH);
            end
        end else if (r_state == CALC && !bus.abort) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_quotient  <= w_quo_next;
                r_remainder <= w_rem_next[WIDTH-1:0];
                r_dbz       <= 1'b0;
            end
        end
    end

    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = (r_state == DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule

`default_nettype wire

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Sequential restoring-divider controller for the divider tile. It accepts an unsigned dividend/divisor pair on a start pulse and iterates one shift-subtract step per clock for WIDTH cycles. It then publishes quotient and remainder with a one-cycle done pulse. The tt_um_devider wrapper instantiates it and maps it onto ui_in, uio_in and uo_out.

Parameters:
WIDTH, 8, operand/result width in bits (2..16)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
abort  input  1  synchronous cancel of an in-flight operation
dividend  input  WIDTH  unsigned dividend, captured on accepted start
divisor  input  WIDTH  unsigned divisor, captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  registered quotient, held until next completion
remainder  output  WIDTH  registered remainder, held until next completion
div_by_zero  output  1  registered flag for the last completed op, held like quotient

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; working regs and counter cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1, divisor!=0:
  - Capture divisor.
  - Working quotient/shift reg = dividend; partial remainder = 0 (WIDTH+1 bits).
  - Counter = WIDTH; next state CALC.
- IDLE, start=1, divisor==0:
  - Next state DONE directly.
  - Output regs load quotient = all ones, remainder = dividend, div_by_zero=1.
- CALC, each edge, one restoring step:
  - Shift the {rem, quo} pair left by 1.
  - trial = rem - divisor; if non-negative, rem = trial and quo LSB = 1, else quo LSB = 0.
  - Counter decrements.
  - On the edge where the counter goes 1->0: next state DONE; output regs load quo, rem[WIDTH-1:0] and div_by_zero=0.
- DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- Latency, start accepted at edge E0:
  - Nonzero divisor: done high for the cycle following edge E0+WIDTH.
  - Zero divisor: done high for the cycle following E0.
- busy is combinational from state: 1 in CALC and DONE.
- start while busy (CALC or DONE) is ignored, with no queueing. A start held high through DONE is accepted on the first IDLE cycle.
- abort=1 in CALC: next state IDLE, no done pulse, output regs unchanged. abort in IDLE or DONE has no effect. abort and start together in IDLE: abort wins and start is not accepted.
- dividend/divisor may change freely after acceptance; only captured values are used.
- Reset asserted mid-operation: immediate return to reset values, including clearing of the previously held results.
- No overflow is possible: the remainder is always < divisor and fits WIDTH bits, with the extra working bit used only for the trial subtract.

Decomposition:
- Package div_pkg: state enum (IDLE, CALC, DONE), default WIDTH constant, counter width function clog2(WIDTH+1).
- One combinational sub-module div_step: inputs rem, quo, divisor; outputs next rem and next quo for one restoring iteration. It is instantiated once; the FSM, counter and output registers live in div_sequencer.

Test Plan:
- WIDTH=8, start with 100/7 -> busy rises next cycle; done pulses 8 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0; busy=0 on the following cycle.
- 255/1, then 0/3, then 200/200 -> (255,0), (0,0), (1,0); each done pulse is exactly 1 cycle wide.
- 5/0 -> done on the cycle after acceptance; quotient=255, remainder=5, div_by_zero=1. A following 9/4 clears the flag: quotient=2, remainder=1.
- Start 100/7, pulse start with 50/5 at cycle 3, change the input buses mid-op -> second request ignored; result remains 14/2; done pulses exactly once.
- Complete 100/7, then start 60/8 and assert abort at cycle 4 -> IDLE next cycle, no done pulse, outputs remain 14/2. A new 60/8 then yields 7/4.
- Start 100/7, assert rst at cycle 5 -> busy, done, quotient, remainder and div_by_zero are all 0 immediately. Deassert rst, run 9/2 -> 4/1.
